div_32_seq: RTL and testbench

//  Iterative signed 32/32 divider for the Mini-SRC datapath; the inverse of the

---
 rtl/mini_src_div_pkg.sv | 17 +
 rtl/div_sign_fix.sv | 13 +
 rtl/div_32_seq.sv | 126 ++++++++++++
 tb/tb_div_32_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_div_pkg.sv
// Shared types and constants for the Mini-SRC sequential signed divider.
// The divider sequences through IDLE, CALC, FIX and DONE states.
package mini_src_div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient reported on divide-by-zero.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate.
// Used for the operand magnitudes and for the final quotient/remainder sign fix-up.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);

    assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/div_32_seq.sv
// Iterative signed divider: one non-restoring quotient bit per cycle on magnitudes.
// The sign fix-up happens in FIX. Quotient goes to LO and remainder to HI.
module div_32_seq
    import mini_src_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    div_state_t state_reg, state_next;

    // The partial remainder is kept in WIDTH+2 signed bits.
    // This lets 2*rem +/- |B| stay exact even when |B| = 2^(WIDTH-1).
    logic [WIDTH+1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sign_q_reg, sign_r_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             div_zero_reg;

    logic [WIDTH-1:0] abs_a, abs_b, quo_fixed, rem_fixed, rem_mag;
    logic [WIDTH+1:0] rem_shift, rem_step, dvs_ext;
    logic             b_zero, calc_last;

    // Unsigned WIDTH-bit magnitudes; |-2^(WIDTH-1)| wraps to exactly 2^(WIDTH-1).
    div_sign_fix #(.W(WIDTH)) u_abs_a (.in_val(A), .neg(A[WIDTH-1]), .out_val(abs_a));
    div_sign_fix #(.W(WIDTH)) u_abs_b (.in_val(B), .neg(B[WIDTH-1]), .out_val(abs_b));

    assign b_zero    = (B == '0);
    assign calc_last = (cnt_reg == CNT_W'(WIDTH - 1));
    assign dvs_ext   = {2'b00, dvs_reg};
    assign rem_shift = {rem_reg[WIDTH:0], quo_reg[WIDTH-1]};
    assign rem_step  = rem_reg[WIDTH+1] ? (rem_shift + dvs_ext) : (rem_shift - dvs_ext);

    // The restored remainder is below |B|, so the low WIDTH bits carry the whole value.
    assign rem_mag = rem_reg[WIDTH+1] ? (rem_reg[WIDTH-1:0] + dvs_reg) : rem_reg[WIDTH-1:0];

    div_sign_fix #(.W(WIDTH)) u_fix_q (.in_val(quo_reg), .neg(sign_q_reg), .out_val(quo_fixed));
    div_sign_fix #(.W(WIDTH)) u_fix_r (.in_val(rem_mag), .neg(sign_r_reg), .out_val(rem_fixed));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Divide-by-zero takes a single FIX cycle, so done still trails the start edge by one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = b_zero ? FIX : CALC;
            CALC: if (calc_last) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == CALC) || (state_reg == FIX);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            cnt_reg      <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rem_reg      <= '0;
                        quo_reg      <= abs_a;
                        dvs_reg      <= abs_b;
                        cnt_reg      <= '0;
                        sign_q_reg   <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r_reg   <= A[WIDTH-1];
                        div_zero_reg <= b_zero;
                        if (b_zero) begin
                            hi_reg <= A;
                            lo_reg <= DIV0_QUOTIENT[WIDTH-1:0];
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_step;
                    quo_reg <= {quo_reg[WIDTH-2:0], ~rem_step[WIDTH+1]};
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                FIX: begin
                    if (!div_zero_reg) begin
                        hi_reg <= rem_fixed;
                        lo_reg <= quo_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI       = hi_reg;
    assign LO       = lo_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: vector table, random pairs vs. a $signed model,
// plus hand sequences for reset mid-operation and ignored start pulses.
module tb_div_32_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] HI, LO;
    logic        busy, done, div_zero;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[14];

    div_32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .clear(clear), .start(start), .A(A), .B(B),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        e.dz  = 1'b0;
        e.lat = 33;
        if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.hi = 32'd0;
            e.lo = 32'h8000_0000;
        end else begin
            e.lo = sa / sb;
            e.hi = sa % sb;
        end
        return e;
    endfunction

    // Drive one division.
    // With poke set, start is re-asserted with other operands throughout busy and DONE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit poke);
        exp_t        got;
        int          n;
        int          busy_n;
        logic [31:0] hold_hi, hold_lo;
        @(negedge clock);
        A = a;
        B = b;
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        @(negedge clock);
        n = 0;
        busy_n = 0;
        while (!done && n < 100) begin
            if (busy) busy_n++;
            if (poke && busy) begin
                A = 32'd7;
                B = 32'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        check("latency", 32'(n), 32'(e.lat));
        check("busy_cycles", 32'(busy_n), 32'(e.lat));
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("LO", LO, got.lo);
            check("HI", HI, got.hi);
            check("div_zero", 32'(div_zero), 32'(got.dz));
        end
        $display("op a=%h b=%h -> LO=%h HI=%h dz=%b lat=%0d", a, b, LO, HI, div_zero, n);
        hold_hi = HI;
        hold_lo = LO;
        @(negedge clock);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        check("hi_hold", HI, hold_hi);
        check("lo_hold", LO, hold_lo);
    endtask

    initial begin
        exp_t e;
        logic [31:0] ra, rb;

        vecs[0]  = '{32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
        vecs[1]  = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33};
        vecs[2]  = '{32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0, 33};
        vecs[3]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,        1'b0, 33};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
        vecs[5]  = '{32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{32'd9,         32'd3,         32'd0,         32'd3,         1'b0, 33};
        vecs[7]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 33};
        vecs[8]  = '{32'h7FFF_FFFF, 32'd1,         32'd0,         32'h7FFF_FFFF, 1'b0, 33};
        vecs[9]  = '{32'h8000_0000, 32'd1,         32'd0,         32'h8000_0000, 1'b0, 33};
        vecs[10] = '{32'h8000_0000, 32'h8000_0000, 32'd0,         32'd1,         1'b0, 33};
        vecs[11] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0,         1'b0, 33};
        vecs[12] = '{32'd1,         32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b0, 33};
        vecs[13] = '{32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1};

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        clear = 1'b1;

        for (int i = 0; i < 14; i++) begin
            e.hi  = vecs[i].hi;
            e.lo  = vecs[i].lo;
            e.dz  = vecs[i].dz;
            e.lat = vecs[i].lat;
            do_op(vecs[i].a, vecs[i].b, e, 1'b0);
        end

        // Leave a zero-divide result in place, then clear in the middle of 1000/3.
        do_op(32'd5, 32'd0, ref_div(32'd5, 32'd0), 1'b0);
        @(negedge clock);
        A = 32'd1000;
        B = 32'd3;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_hi_hold", HI, 32'd5);
        check("calc_lo_hold", LO, 32'hFFFF_FFFF);
        #2;
        clear = 1'b0;
        #1;
        check("clr_HI", HI, 32'd0);
        check("clr_LO", LO, 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_div_zero", 32'(div_zero), 32'd0);
        @(negedge clock);
        clear = 1'b1;

        // Restart after clear, with start pulses during busy and DONE that must be ignored.
        do_op(32'd1000, 32'd3, ref_div(32'd1000, 32'd3), 1'b1);
        do_op(32'hFFFF_FC18, 32'd3, ref_div(32'hFFFF_FC18, 32'd3), 1'b1);

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
            if (i % 5 == 1) rb = 32'd0 - rb;
            if (rb == 32'd0) rb = 32'd1;
            do_op(ra, rb, ref_div(ra, rb), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
